// File: rtl/rng_neighbor_select_pkg.sv
// Shared constants and types for the neighbor selector: word width, LFSR seed/taps,
// FSM states and the data-memory geometry that the neighbor table lives in.
package rng_neighbor_select_pkg;

    localparam int          WORD_WIDTH   = 16;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 in right-shift form: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS    = 16'h002D;

    localparam int          MEM_DEPTH    = 2048;
    localparam int          MEM_WIDTH    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } sel_state_t;

endpackage

// File: rtl/rng_neighbor_select_if.sv
// Bus between the routing/winner-policy FSM (master) and the neighbor selector (slave).
interface rng_neighbor_select_if;
    import rng_neighbor_select_pkg::*;

    logic                  start;
    logic [WORD_WIDTH-1:0] count;
    logic [WORD_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_data;
    logic [WORD_WIDTH-1:0] rng_out;
    logic [WORD_WIDTH-1:0] rng_out_4bit;
    logic [WORD_WIDTH-1:0] which;
    logic [WORD_WIDTH-1:0] rng_address;
    logic                  done;

    modport master (
        output start, count, mem_addr, mem_data,
        input  rng_out, rng_out_4bit, which, rng_address, done
    );

    modport slave (
        input  start, count, mem_addr, mem_data,
        output rng_out, rng_out_4bit, which, rng_address, done
    );

endinterface

// File: rtl/rng_neighbor_select_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR with an optional XOR mix input.
// An all-zero next state is replaced by the seed so the sequence can never lock up.
module lfsr16
    import rng_neighbor_select_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        i_clock,
    input  logic        i_nreset,
    input  logic [15:0] i_mix,
    output logic [15:0] o_state
);

    logic [15:0] r_state;
    logic        w_fb;
    logic [15:0] w_next;

    always_comb begin
        w_fb   = ^(r_state & LFSR_TAPS);
        w_next = {w_fb, r_state[15:1]} ^ i_mix;
    end

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset)
            r_state <= SEED;
        else if (w_next == 16'h0000)
            r_state <= SEED;
        else
            r_state <= w_next;
    end

    assign o_state = r_state;

endmodule

// File: rtl/rng_neighbor_select.sv
// Random neighbor selector: captures an LFSR word on start, reduces it modulo count by
// restoring division, returns index and table byte address. Build option: RNG_ENTROPY_MIX_EN.
//
//   state   | meaning
//   IDLE    | waiting for start; last result held on which/rng_address
//   DIV     | one quotient bit per clock, 16 clocks
//   DONE    | done=1, result held until start drops
module rng_neighbor_select
    import rng_neighbor_select_pkg::*;
#(
    parameter logic [15:0] SEED        = DEFAULT_SEED,
    parameter logic [15:0] BASE_ADDR   = 16'h0100,
    parameter int          ENTRY_SHIFT = 1
) (
    input  logic                 i_clock,
    input  logic                 i_nreset,
    rng_neighbor_select_if.slave bus
);

    logic [15:0] w_mix;
    logic [15:0] w_rng;

`ifdef RNG_ENTROPY_MIX_EN
    assign w_mix = bus.mem_data ^ bus.mem_addr;
`else
    logic w_unused_mem;
    assign w_mix        = 16'h0000;
    assign w_unused_mem = ^{bus.mem_data, bus.mem_addr};
`endif

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .i_clock  (i_clock),
        .i_nreset (i_nreset),
        .i_mix    (w_mix),
        .o_state  (w_rng)
    );

    sel_state_t  r_state;
    logic [15:0] r_dividend;
    logic [15:0] r_divisor;
    logic [16:0] r_rem;
    logic [3:0]  r_bit_cnt;
    logic [15:0] r_which;
    logic [15:0] r_addr;
    logic        r_done;

    logic [16:0] w_rem_shift;
    logic [16:0] w_rem_next;
    logic [15:0] w_offset;

    // Remainder stays below the 16-bit divisor, so the 17-bit shift never loses a bit
    always_comb begin
        w_rem_shift = {r_rem[15:0], r_dividend[15]};
        if (w_rem_shift >= {1'b0, r_divisor})
            w_rem_next = w_rem_shift - {1'b0, r_divisor};
        else
            w_rem_next = w_rem_shift;
        w_offset = w_rem_next[15:0] << ENTRY_SHIFT;
    end

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state    <= ST_IDLE;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_bit_cnt  <= '0;
            r_which    <= '0;
            r_addr     <= '0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_dividend <= w_rng;
                        r_divisor  <= bus.count;
                        if (bus.count == 16'h0000) begin
                            r_which <= '0;
                            r_addr  <= BASE_ADDR;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_rem     <= '0;
                            r_bit_cnt <= '0;
                            r_state   <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    r_rem      <= w_rem_next;
                    r_dividend <= r_dividend << 1;
                    r_bit_cnt  <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd15) begin
                        r_which <= w_rem_next[15:0];
                        r_addr  <= BASE_ADDR + w_offset;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!bus.start) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rng_out      = w_rng;
    assign bus.rng_out_4bit = {12'h000, w_rng[3:0]};
    assign bus.which        = r_which;
    assign bus.rng_address  = r_addr;
    assign bus.done         = r_done;

endmodule

// File: tb/tb_rng_neighbor_select.sv
// Directed + randomized bench for rng_neighbor_select against an arithmetic reference model.
module tb_rng_neighbor_select;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] BASE = 16'h0100;

    logic clk;
    logic nreset;

    rng_neighbor_select_if bus();

    rng_neighbor_select dut (
        .i_clock  (clk),
        .i_nreset (nreset),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          rng_bad  = 0;
    int          rng_zero = 0;
    logic [15:0] exp_rng;
    logic [15:0] captured;
    logic [15:0] cnt_val;
    logic [15:0] exp_which;
    logic [15:0] exp_addr;

    // Reference LFSR: parity of taps 0,2,3,5 shifted in at the top; zero replaced by seed
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        int          fb;
        logic [15:0] n;
        fb = s[0] + s[2] + s[3] + s[5];
        n  = (s >> 1) | ((fb % 2 == 1) ? 16'h8000 : 16'h0000);
        return (n == 16'h0000) ? SEED : n;
    endfunction

    function automatic logic [15:0] model_which(input logic [15:0] d, input logic [15:0] c);
        int unsigned q;
        if (c == 0) return 16'h0000;
        q = int'(d) % int'(c);
        return q[15:0];
    endfunction

    function automatic logic [15:0] model_addr(input logic [15:0] w);
        int unsigned a;
        a = (32'(BASE) + 32'(w) * 2) % 65536;
        return a[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        exp_rng = lfsr_next(exp_rng);
        if (bus.rng_out !== exp_rng) rng_bad++;
        if (bus.rng_out == 16'h0000) rng_zero++;
        bus.mem_addr = 16'($urandom);
        bus.mem_data = 16'($urandom);
    endtask

    task automatic reset_now();
        nreset  = 1'b0;
        exp_rng = SEED;
        #2;
        nreset  = 1'b1;
    endtask

    task automatic run_select(input string tag, input logic [15:0] c, input bit scramble);
        bus.start = 1'b1;
        bus.count = c;
        captured  = exp_rng;
        exp_which = model_which(captured, c);
        exp_addr  = model_addr(exp_which);
        tick();
        if (c != 0) begin
            for (int k = 2; k <= 16; k++) begin
                if (scramble) begin
                    bus.count = 16'($urandom);
                    bus.start = 1'($urandom_range(0, 1));
                end
                tick();
            end
            check({tag, "_done_early"}, 32'(bus.done), 32'd0);
            tick();
        end
        check({tag, "_done"},  32'(bus.done),        32'd1);
        check({tag, "_which"}, 32'(bus.which),       32'(exp_which));
        check({tag, "_addr"},  32'(bus.rng_address), 32'(exp_addr));
        bus.start = 1'b0;
        tick();
        check({tag, "_done_clear"}, 32'(bus.done),   32'd0);
        check({tag, "_hold"},       32'(bus.which),  32'(exp_which));
    endtask

    initial begin
        int early_seed;
        nreset       = 1'b0;
        bus.start    = 1'b0;
        bus.count    = 16'h0000;
        bus.mem_addr = 16'h0000;
        bus.mem_data = 16'h0000;
        exp_rng      = SEED;
        #12;
        check("rst_rng",   32'(bus.rng_out),      32'h0000ACE1);
        check("rst_rng4",  32'(bus.rng_out_4bit), 32'h00000001);
        check("rst_done",  32'(bus.done),         32'd0);
        check("rst_which", 32'(bus.which),        32'd0);
        check("rst_addr",  32'(bus.rng_address),  32'd0);
        nreset = 1'b1;

        // count=7 from the very first edge: 44257 mod 7 = 3
        bus.start = 1'b1;
        bus.count = 16'd7;
        tick();
        check("step1_rng",  32'(bus.rng_out),      32'h00005670);
        check("step1_rng4", 32'(bus.rng_out_4bit), 32'h00000000);
        check("step1_done", 32'(bus.done),         32'd0);
        for (int k = 2; k <= 16; k++) tick();
        check("c7_done_early", 32'(bus.done), 32'd0);
        tick();
        check("c7_done",  32'(bus.done),        32'd1);
        check("c7_which", 32'(bus.which),       32'd3);
        check("c7_addr",  32'(bus.rng_address), 32'h00000106);
        tick();
        check("c7_done_held", 32'(bus.done), 32'd1);
        bus.start = 1'b0;
        tick();
        check("c7_done_clear", 32'(bus.done),        32'd0);
        check("c7_which_hold", 32'(bus.which),       32'd3);
        check("c7_addr_hold",  32'(bus.rng_address), 32'h00000106);

        // Same captured word with count=3: 44257 mod 3 = 1
        reset_now();
        bus.start = 1'b1;
        bus.count = 16'd3;
        for (int k = 1; k <= 17; k++) tick();
        check("c3_done",  32'(bus.done),        32'd1);
        check("c3_which", 32'(bus.which),       32'd1);
        check("c3_addr",  32'(bus.rng_address), 32'h00000102);
        bus.start = 1'b0;
        tick();
        check("c3_done_clear", 32'(bus.done),        32'd0);
        check("c3_addr_hold",  32'(bus.rng_address), 32'h00000102);

        bus.start = 1'b1;
        bus.count = 16'd0;
        tick();
        check("c0_done",  32'(bus.done),        32'd1);
        check("c0_which", 32'(bus.which),       32'd0);
        check("c0_addr",  32'(bus.rng_address), 32'h00000100);
        bus.start = 1'b0;
        tick();
        check("c0_done_clear", 32'(bus.done), 32'd0);

        // Abort mid-division with an asynchronous reset
        bus.start = 1'b1;
        bus.count = 16'd5;
        for (int k = 1; k <= 6; k++) tick();
        nreset  = 1'b0;
        exp_rng = SEED;
        #1;
        check("abort_done",  32'(bus.done),        32'd0);
        check("abort_which", 32'(bus.which),       32'd0);
        check("abort_addr",  32'(bus.rng_address), 32'd0);
        check("abort_rng",   32'(bus.rng_out),     32'h0000ACE1);
        #1;
        nreset    = 1'b1;
        bus.start = 1'b0;
        tick();
        check("abort_idle_done", 32'(bus.done), 32'd0);
        run_select("after_abort", 16'd9, 1'b0);

        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 5))
                0:       cnt_val = 16'h0000;
                1:       cnt_val = 16'h0001;
                2:       cnt_val = 16'hFFFF;
                3:       cnt_val = 16'($urandom_range(2, 15));
                default: cnt_val = 16'($urandom);
            endcase
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            run_select($sformatf("rand%0d", it), cnt_val, 1'b1);
        end
        check("rng_track", 32'(rng_bad), 32'd0);

        // Full period with no activity
        reset_now();
        bus.start  = 1'b0;
        rng_zero   = 0;
        early_seed = 0;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            if (i < 65535 && bus.rng_out == SEED) early_seed++;
        end
        check("period_nonzero", 32'(rng_zero),    32'd0);
        check("period_early",   32'(early_seed),  32'd0);
        check("period_return",  32'(bus.rng_out), 32'h0000ACE1);
        check("period_track",   32'(rng_bad),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
